key_loader_obf: RTL and testbench

- Producer side of the `locking_key` interface consumed by the obfuscated calculate blocks.
- Fetches the 255-bit key word-by-word from a key store over a request/valid read port.
- Checks the fetched words against an XOR signature and drives `locking_key` with the assembled key only on a match. Otherwise it drives all-zero, so the consumer stays functionally locked.
- Uses the same `ap_start`/`ap_done`/`ap_idle`/`ap_ready` block handshake as the consumers.

---
 rtl/key_loader_obf.sv | 170 +++++++++++++++++
 tb/tb_key_loader_obf.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_loader_obf.sv
// Key loader for the obfuscated calculate blocks: fetches the locking key from the key store
// one word at a time, checks its XOR signature, and releases the key only on a signature match.
module key_loader_obf #(
    parameter int KEY_WIDTH  = 255,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_idle,
    output logic                          ap_ready,
    output logic                          key_rd_en,
    output logic [$clog2(NUM_WORDS)-1:0]  key_rd_addr,
    input  logic [WORD_WIDTH-1:0]         key_rd_data,
    input  logic                          key_rd_valid,
    input  logic [WORD_WIDTH-1:0]         expected_sig,
    output logic [KEY_WIDTH-1:0]          locking_key,
    output logic                          key_valid,
    output logic                          key_error
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    // Bits of the last word that fall beyond KEY_WIDTH take no part in the key or the signature.
    localparam logic [WORD_WIDTH-1:0] LAST_MASK =
        {WORD_WIDTH{1'b1}} >> (NUM_WORDS * WORD_WIDTH - KEY_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   acc_q, acc_d;
    logic [KEY_WIDTH-1:0]    kbuf_q, kbuf_d;
    logic [KEY_WIDTH-1:0]    lk_q, lk_d;
    logic                    kv_q, kv_d;
    logic                    ke_q, ke_d;
    logic                    idle_q, idle_d;
    logic                    done_q, done_d;
    logic                    rd_en_q, rd_en_d;
    logic [IDX_W-1:0]        rd_addr_q, rd_addr_d;
    logic [WORD_WIDTH-1:0]   word_masked_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        kbuf_d  = kbuf_q;
        lk_d    = lk_q;
        kv_d    = kv_q;
        ke_d    = ke_q;
        if (idx_q == LAST_IDX) begin
            word_masked_s = key_rd_data & LAST_MASK;
        end else begin
            word_masked_s = key_rd_data;
        end

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_REQ;
                    idx_d   = '0;
                    acc_d   = '0;
                    kbuf_d  = '0;
                    lk_d    = '0;
                    kv_d    = 1'b0;
                    ke_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (key_rd_valid) begin
                    kbuf_d = kbuf_q | (KEY_WIDTH'(word_masked_s) << (int'(idx_q) * WORD_WIDTH));
                    acc_d  = acc_q ^ word_masked_s;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_CHECK;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_REQ;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    ke_d    = 1'b1;
                    kv_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (acc_q == expected_sig) begin
                    lk_d = kbuf_q;
                    kv_d = 1'b1;
                end else begin
                    lk_d = '0;
                    ke_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        idle_d    = (state_d == S_IDLE);
        done_d    = (state_d == S_DONE);
        rd_en_d   = (state_d == S_REQ);
        rd_addr_d = idx_d;
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            kbuf_q    <= '0;
            lk_q      <= '0;
            kv_q      <= 1'b0;
            ke_q      <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            kbuf_q    <= kbuf_d;
            lk_q      <= lk_d;
            kv_q      <= kv_d;
            ke_q      <= ke_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign ap_done     = done_q;
    assign ap_ready    = done_q;
    assign ap_idle     = idle_q;
    assign key_rd_en   = rd_en_q;
    assign key_rd_addr = rd_addr_q;
    assign locking_key = lk_q;
    assign key_valid   = kv_q;
    assign key_error   = ke_q;

endmodule

// File: tb/tb_key_loader_obf.sv
// Directed bench for key_loader_obf: a latency-configurable key-store responder plus
// per-scenario tasks with hand-computed expectations.
module tb_key_loader_obf;

    logic         ap_clk = 1'b0;
    logic         ap_rst = 1'b1;
    logic         ap_start = 1'b0;
    logic         ap_done, ap_idle, ap_ready;
    logic         key_rd_en;
    logic [2:0]   key_rd_addr;
    logic [31:0]  key_rd_data = 32'h0;
    logic         key_rd_valid = 1'b0;
    logic [31:0]  expected_sig = 32'h0;
    logic [254:0] locking_key;
    logic         key_valid, key_error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0]  mem [0:7];
    logic [254:0] exp_key;
    int rd_lat    = 1;
    int withhold  = -1;
    int resp_addr = 0;

    key_loader_obf dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .key_rd_en(key_rd_en), .key_rd_addr(key_rd_addr),
        .key_rd_data(key_rd_data), .key_rd_valid(key_rd_valid),
        .expected_sig(expected_sig), .locking_key(locking_key),
        .key_valid(key_valid), .key_error(key_error)
    );

    always #5 ap_clk = ~ap_clk;

    // Key-store model: answers each request after rd_lat cycles unless its word is withheld.
    always begin
        @(negedge ap_clk);
        if (key_rd_en === 1'b1) begin
            resp_addr = int'(key_rd_addr);
            if (resp_addr != withhold) begin
                repeat (rd_lat - 1) @(negedge ap_clk);
                @(posedge ap_clk);
                #1;
                key_rd_valid = 1'b1;
                key_rd_data  = mem[resp_addr];
                @(posedge ap_clk);
                #1;
                key_rd_valid = 1'b0;
                key_rd_data  = 32'h0;
            end
        end
    end

    // Runs one load; cycle 1 is the cycle right after the edge that samples ap_start.
    task automatic run_load(input bit toggle, output int done_at, output int pulses,
                            output int reads, output int addr_errs, output int ready_errs,
                            output int lk_leaks);
        done_at = -1; pulses = 0; reads = 0; addr_errs = 0; ready_errs = 0; lk_leaks = 0;
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge ap_clk);
            if (toggle) ap_start = (n >= 3 && n <= 25) ? n[0] : 1'b0;
            if (ap_ready !== ap_done) ready_errs++;
            if (key_rd_en === 1'b1) begin
                if (int'(key_rd_addr) != reads) addr_errs++;
                reads++;
            end
            if (ap_done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = n;
            end else if (done_at < 0 && locking_key !== 255'h0) begin
                lk_leaks++;
            end
            if (done_at >= 0 && n >= done_at + 3) break;
        end
        ap_start = 1'b0;
    endtask

    task automatic test_reset();
        int rd_seen;
        rd_seen = 0;
        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            if (key_rd_en !== 1'b0) rd_seen++;
        end
        total_cnt++; if (ap_idle !== 1'b1) $display("FAIL reset_idle got %b want 1", ap_idle); else pass_cnt++;
        total_cnt++; if (locking_key !== 255'h0) $display("FAIL reset_key got %h want 0", locking_key); else pass_cnt++;
        total_cnt++; if (rd_seen !== 0) $display("FAIL reset_rd_en got %0d pulses want 0", rd_seen); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", key_valid); else pass_cnt++;
        total_cnt++; if (key_error !== 1'b0) $display("FAIL reset_error got %b want 0", key_error); else pass_cnt++;
        total_cnt++; if (ap_done !== 1'b0) $display("FAIL reset_done got %b want 0", ap_done); else pass_cnt++;
    endtask

    task automatic test_pass();
        int d, p, r, ae, re, lk;
        rd_lat = 1; withhold = -1; expected_sig = 32'h08888888;
        run_load(1'b0, d, p, r, ae, re, lk);
        total_cnt++; if (d !== 18) $display("FAIL pass_done_cycle got %0d want 18", d); else pass_cnt++;
        total_cnt++; if (p !== 1) $display("FAIL pass_done_pulses got %0d want 1", p); else pass_cnt++;
        total_cnt++; if (r !== 8) $display("FAIL pass_reads got %0d want 8", r); else pass_cnt++;
        total_cnt++; if (ae !== 0) $display("FAIL pass_addr_order got %0d bad want 0", ae); else pass_cnt++;
        total_cnt++; if (re !== 0) $display("FAIL pass_ready_eq_done got %0d bad want 0", re); else pass_cnt++;
        total_cnt++; if (lk !== 0) $display("FAIL pass_key_locked_during_load got %0d bad want 0", lk); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b1) $display("FAIL pass_valid got %b want 1", key_valid); else pass_cnt++;
        total_cnt++; if (key_error !== 1'b0) $display("FAIL pass_error got %b want 0", key_error); else pass_cnt++;
        total_cnt++; if (locking_key[32:0] !== 33'h011111111) $display("FAIL pass_key_low got %h want 011111111", locking_key[32:0]); else pass_cnt++;
        total_cnt++; if (locking_key[254:224] !== 31'h08888888) $display("FAIL pass_key_top got %h want 08888888", locking_key[254:224]); else pass_cnt++;
        total_cnt++; if (locking_key !== exp_key) $display("FAIL pass_key_full got %h want %h", locking_key, exp_key); else pass_cnt++;
    endtask

    task automatic test_persist();
        repeat (6) @(negedge ap_clk);
        total_cnt++; if (key_valid !== 1'b1) $display("FAIL persist_valid got %b want 1", key_valid); else pass_cnt++;
        total_cnt++; if (locking_key !== exp_key) $display("FAIL persist_key got %h want %h", locking_key, exp_key); else pass_cnt++;
        total_cnt++; if (ap_idle !== 1'b1) $display("FAIL persist_idle got %b want 1", ap_idle); else pass_cnt++;
    endtask

    task automatic test_sig_mismatch();
        int d, p, r, ae, re, lk;
        rd_lat = 1; withhold = -1; expected_sig = 32'h08888889;
        run_load(1'b0, d, p, r, ae, re, lk);
        total_cnt++; if (d !== 18) $display("FAIL bad_sig_done_cycle got %0d want 18", d); else pass_cnt++;
        total_cnt++; if (p !== 1) $display("FAIL bad_sig_done_pulses got %0d want 1", p); else pass_cnt++;
        total_cnt++; if (key_error !== 1'b1) $display("FAIL bad_sig_error got %b want 1", key_error); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b0) $display("FAIL bad_sig_valid got %b want 0", key_valid); else pass_cnt++;
        total_cnt++; if (locking_key !== 255'h0) $display("FAIL bad_sig_key got %h want 0", locking_key); else pass_cnt++;
    endtask

    task automatic test_latency_toggle();
        int d, p, r, ae, re, lk;
        rd_lat = 3; withhold = -1; expected_sig = 32'h08888888;
        run_load(1'b1, d, p, r, ae, re, lk);
        total_cnt++; if (d !== 34) $display("FAIL lat3_done_cycle got %0d want 34", d); else pass_cnt++;
        total_cnt++; if (p !== 1) $display("FAIL lat3_done_pulses got %0d want 1", p); else pass_cnt++;
        total_cnt++; if (r !== 8) $display("FAIL lat3_reads got %0d want 8", r); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b1) $display("FAIL lat3_valid got %b want 1", key_valid); else pass_cnt++;
        total_cnt++; if (key_error !== 1'b0) $display("FAIL lat3_error got %b want 0", key_error); else pass_cnt++;
        total_cnt++; if (locking_key !== exp_key) $display("FAIL lat3_key got %h want %h", locking_key, exp_key); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int d, p, r, ae, re, lk;
        rd_lat = 1; withhold = 3; expected_sig = 32'h08888888;
        run_load(1'b0, d, p, r, ae, re, lk);
        // Words 0..2 take cycles 1-6, REQ3 is cycle 7, 255 WAIT cycles 8-262, DONE in 263.
        total_cnt++; if (d !== 263) $display("FAIL timeout_done_cycle got %0d want 263", d); else pass_cnt++;
        total_cnt++; if (p !== 1) $display("FAIL timeout_done_pulses got %0d want 1", p); else pass_cnt++;
        total_cnt++; if (r !== 4) $display("FAIL timeout_reads got %0d want 4", r); else pass_cnt++;
        total_cnt++; if (key_error !== 1'b1) $display("FAIL timeout_error got %b want 1", key_error); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b0) $display("FAIL timeout_valid got %b want 0", key_valid); else pass_cnt++;
        total_cnt++; if (locking_key !== 255'h0) $display("FAIL timeout_key got %h want 0", locking_key); else pass_cnt++;
        withhold = -1;
    endtask

    task automatic test_reset_mid_load();
        int found, activity, d, p, r, ae, re, lk;
        found = 0; activity = 0;
        rd_lat = 1; withhold = 5; expected_sig = 32'h08888888;
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge ap_clk);
            if (key_rd_addr === 3'd5 && key_rd_en === 1'b0 && ap_idle === 1'b0) begin
                found = 1;
                break;
            end
        end
        total_cnt++; if (found !== 1) $display("FAIL rst_mid_reach_wait5 got %0d want 1", found); else pass_cnt++;
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        key_rd_valid = 1'b1;
        key_rd_data  = 32'hDEADBEEF;
        @(negedge ap_clk);
        key_rd_valid = 1'b0;
        key_rd_data  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            if (key_rd_en !== 1'b0 || ap_done !== 1'b0 || ap_idle !== 1'b1) activity++;
        end
        total_cnt++; if (activity !== 0) $display("FAIL rst_mid_quiet got %0d bad cycles want 0", activity); else pass_cnt++;
        total_cnt++; if (key_rd_addr !== 3'd0) $display("FAIL rst_mid_addr got %0d want 0", key_rd_addr); else pass_cnt++;
        total_cnt++; if (locking_key !== 255'h0) $display("FAIL rst_mid_key got %h want 0", locking_key); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b0 || key_error !== 1'b0) $display("FAIL rst_mid_flags got %b%b want 00", key_valid, key_error); else pass_cnt++;
        withhold = -1;
        run_load(1'b0, d, p, r, ae, re, lk);
        total_cnt++; if (d !== 18) $display("FAIL rst_fresh_done_cycle got %0d want 18", d); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b1) $display("FAIL rst_fresh_valid got %b want 1", key_valid); else pass_cnt++;
        total_cnt++; if (locking_key !== exp_key) $display("FAIL rst_fresh_key got %h want %h", locking_key, exp_key); else pass_cnt++;
    endtask

    initial begin
        mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        mem[4] = 32'h55555555; mem[5] = 32'h66666666; mem[6] = 32'h77777777; mem[7] = 32'h88888888;
        exp_key = {31'h08888888, 32'h77777777, 32'h66666666, 32'h55555555,
                   32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        test_reset();
        test_pass();
        test_persist();
        test_sig_mismatch();
        test_latency_toggle();
        test_timeout();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
